// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand select, EX/MEM and MEM/WB forwarding, load-use detect.
// Latency: 1 cycle ID->EX; operands, forwarding and load_use_stall_o are combinational off EX state.
// Backpressure: stall_i freezes EX (rs data keep refreshing); load_use_stall_o asks upstream to hold.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [REGW-1:0] id_rs1_i,
    input  logic [REGW-1:0] id_rs2_i,
    input  logic [REGW-1:0] id_rd_i,
    input  logic [3:0]      id_alu_ctrl_i,
    input  logic            id_alusrc_i,
    input  logic            id_auipc_i,
    input  logic            id_reg_write_i,
    input  logic            id_mem_read_i,
    input  logic            id_mem_write_i,
    input  logic            id_mem_to_reg_i,
    input  logic            exmem_reg_write_i,
    input  logic [REGW-1:0] exmem_rd_i,
    input  logic [XLEN-1:0] exmem_result_i,
    input  logic            memwb_reg_write_i,
    input  logic [REGW-1:0] memwb_rd_i,
    input  logic [XLEN-1:0] memwb_result_i,
    output logic [XLEN-1:0] operand1_o,
    output logic [XLEN-1:0] operand2_o,
    output logic [3:0]      alu_ctrl_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [REGW-1:0] ex_rd_o,
    output logic            ex_valid_o,
    output logic            ex_reg_write_o,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic            ex_mem_to_reg_o,
    output logic            load_use_stall_o
);

    logic            ex_valid;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_mem_to_reg;
    logic            ex_alusrc;
    logic            ex_auipc;
    logic [3:0]      ex_alu_ctrl;
    logic [REGW-1:0] ex_rd;
    logic [REGW-1:0] ex_rs1;
    logic [REGW-1:0] ex_rs2;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            bubble;

    // EX/MEM beats MEM/WB; x0 never forwards; bubbles see raw registered data.
    always_comb begin
        fwd_rs1 = ex_rs1_data;
        fwd_rs2 = ex_rs2_data;
        if (ex_valid) begin
            if (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == ex_rs1)
                fwd_rs1 = exmem_result_i;
            else if (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == ex_rs1)
                fwd_rs1 = memwb_result_i;

            if (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == ex_rs2)
                fwd_rs2 = exmem_result_i;
            else if (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == ex_rs2)
                fwd_rs2 = memwb_result_i;
        end
    end

    // rs2 is compared even for I-type: a spurious stall is cheaper than a missed one.
    always_comb begin
        load_use_stall_o = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid_i &&
                           ((ex_rd == id_rs1_i) || (ex_rd == id_rs2_i));
    end

    // Reset and flush share the all-zero bubble; a stall defers the load-use bubble.
    assign bubble = rst_i || flush_i || (!stall_i && load_use_stall_o);

    always_ff @(posedge clk_i) begin
        if (bubble) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alusrc     <= 1'b0;
            ex_auipc      <= 1'b0;
            ex_alu_ctrl   <= '0;
            ex_rd         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_pc         <= '0;
            ex_imm        <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
        end else if (stall_i) begin
            // Capture producers retiring out of MEM/WB while EX is frozen.
            ex_rs1_data <= fwd_rs1;
            ex_rs2_data <= fwd_rs2;
        end else begin
            ex_valid      <= id_valid_i;
            ex_reg_write  <= id_reg_write_i;
            ex_mem_read   <= id_mem_read_i;
            ex_mem_write  <= id_mem_write_i;
            ex_mem_to_reg <= id_mem_to_reg_i;
            ex_alusrc     <= id_alusrc_i;
            ex_auipc      <= id_auipc_i;
            ex_alu_ctrl   <= id_alu_ctrl_i;
            ex_rd         <= id_rd_i;
            ex_rs1        <= id_rs1_i;
            ex_rs2        <= id_rs2_i;
            ex_pc         <= id_pc_i;
            ex_imm        <= id_imm_i;
            ex_rs1_data   <= id_rs1_data_i;
            ex_rs2_data   <= id_rs2_data_i;
        end
    end

    assign operand1_o      = ex_auipc  ? ex_pc  : fwd_rs1;
    assign operand2_o      = ex_alusrc ? ex_imm : fwd_rs2;
    assign ex_store_data_o = fwd_rs2;
    assign alu_ctrl_o      = ex_alu_ctrl;
    assign ex_rd_o         = ex_rd;
    assign ex_valid_o      = ex_valid;
    assign ex_reg_write_o  = ex_reg_write;
    assign ex_mem_read_o   = ex_mem_read;
    assign ex_mem_write_o  = ex_mem_write;
    assign ex_mem_to_reg_o = ex_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Vector table plus scoreboard bench for id_ex_stage; each step drives at negedge and checks before the next posedge.
module tb_id_ex_stage;

    typedef struct packed {
        logic        rst, stall, flush, valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        alusrc, auipc, rw, mr, mw, m2r;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
    } in_t;

    typedef struct packed {
        logic [31:0] op1, op2;
        logic [3:0]  alu;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        v, rw, mr, mw, m2r, lus;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
        logic chk;
    } vec_t;

    logic        clk;
    logic        rst_i, stall_i, flush_i, id_valid_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [3:0]  id_alu_ctrl_i;
    logic        id_alusrc_i, id_auipc_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
    logic        exmem_reg_write_i, memwb_reg_write_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_result_i, memwb_result_i;
    logic [31:0] operand1_o, operand2_o, ex_store_data_o;
    logic [3:0]  alu_ctrl_o;
    logic [4:0]  ex_rd_o;
    logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o;
    logic        load_use_stall_o;

    int   vectors = 0;
    int   miscompares = 0;
    out_t sb[$];
    vec_t tbl[$];

    id_ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_alu_ctrl_i(id_alu_ctrl_i), .id_alusrc_i(id_alusrc_i), .id_auipc_i(id_auipc_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
        .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
        .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
        .operand1_o(operand1_o), .operand2_o(operand2_o), .alu_ctrl_o(alu_ctrl_o),
        .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
        .load_use_stall_o(load_use_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {alusrc, auipc, reg_write, mem_read, mem_write, mem_to_reg}
    function automatic in_t inst(logic [31:0] pc, logic [31:0] rs1d, logic [31:0] rs2d, logic [31:0] imm,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [3:0] alu,
                                 logic [5:0] ctl);
        in_t r = '0;
        r.valid = 1'b1;
        r.pc = pc; r.rs1d = rs1d; r.rs2d = rs2d; r.imm = imm;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.alu = alu;
        {r.alusrc, r.auipc, r.rw, r.mr, r.mw, r.m2r} = ctl;
        return r;
    endfunction

    function automatic in_t fw(in_t b, logic xw, logic [4:0] xrd, logic [31:0] xres,
                               logic ww, logic [4:0] wrd, logic [31:0] wres);
        in_t r = b;
        r.xw = xw; r.xrd = xrd; r.xres = xres;
        r.ww = ww; r.wrd = wrd; r.wres = wres;
        return r;
    endfunction

    function automatic in_t ctrl_in(in_t b, logic rst, logic stall, logic flush);
        in_t r = b;
        r.rst = rst; r.stall = stall; r.flush = flush;
        return r;
    endfunction

    // ctl = {valid, reg_write, mem_read, mem_write, mem_to_reg}
    function automatic out_t ex(logic [31:0] op1, logic [31:0] op2, logic [3:0] alu, logic [31:0] st,
                                logic [4:0] rd, logic [4:0] ctl, logic lus);
        return {op1, op2, alu, st, rd, ctl, lus};
    endfunction

    task automatic add(input in_t i, input out_t e, input logic chk);
        vec_t v;
        v.in = i; v.exp = e; v.chk = chk;
        tbl.push_back(v);
    endtask

    task automatic apply(input in_t i, input out_t e, input logic chk, input string name);
        out_t got, want;
        @(negedge clk);
        rst_i = i.rst; stall_i = i.stall; flush_i = i.flush; id_valid_i = i.valid;
        id_pc_i = i.pc; id_rs1_data_i = i.rs1d; id_rs2_data_i = i.rs2d; id_imm_i = i.imm;
        id_rs1_i = i.rs1; id_rs2_i = i.rs2; id_rd_i = i.rd; id_alu_ctrl_i = i.alu;
        id_alusrc_i = i.alusrc; id_auipc_i = i.auipc; id_reg_write_i = i.rw;
        id_mem_read_i = i.mr; id_mem_write_i = i.mw; id_mem_to_reg_i = i.m2r;
        exmem_reg_write_i = i.xw; exmem_rd_i = i.xrd; exmem_result_i = i.xres;
        memwb_reg_write_i = i.ww; memwb_rd_i = i.wrd; memwb_result_i = i.wres;
        if (chk) sb.push_back(e);
        #1;
        if (chk) begin
            got = {operand1_o, operand2_o, alu_ctrl_o, ex_store_data_o, ex_rd_o, ex_valid_o,
                   ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, load_use_stall_o};
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got op1=%h op2=%h alu=%h st=%h rd=%0d ctl=%b lus=%b, want op1=%h op2=%h alu=%h st=%h rd=%0d ctl=%b lus=%b",
                         name, got.op1, got.op2, got.alu, got.st, got.rd,
                         {got.v, got.rw, got.mr, got.mw, got.m2r}, got.lus,
                         want.op1, want.op2, want.alu, want.st, want.rd,
                         {want.v, want.rw, want.mr, want.mw, want.m2r}, want.lus);
            end
        end
    endtask

    initial begin
        in_t  nop, a, b, c, d, l, u, s, t, f, l2, u2, sw, l3, u3;
        out_t z, s_ex, l2_ex, a_raw;

        nop = '0;
        z   = '0;
        a   = inst(32'h10,  32'h11,   32'h22,   32'h0,         5'd5, 5'd6,  5'd8,  4'b0010, 6'b001000);
        b   = inst(32'h14,  32'h33,   32'h44,   32'h0,         5'd0, 5'd6,  5'd9,  4'b0110, 6'b001000);
        c   = inst(32'h18,  32'h7,    32'h9,    32'hFFFF_FFF0, 5'd1, 5'd2,  5'd3,  4'b0010, 6'b101000);
        d   = inst(32'h100, 32'h5,    32'h0,    32'h1000,      5'd4, 5'd0,  5'd10, 4'b0010, 6'b111000);
        l   = inst(32'h20,  32'h200,  32'h0,    32'h4,         5'd1, 5'd0,  5'd7,  4'b0010, 6'b101101);
        u   = inst(32'h24,  32'hDEAD, 32'h5,    32'h0,         5'd7, 5'd12, 5'd11, 4'b0010, 6'b001000);
        s   = inst(32'h30,  32'h0BAD, 32'h0,    32'h0,         5'd9, 5'd0,  5'd13, 4'b0010, 6'b001000);
        t   = inst(32'h34,  32'h1,    32'h2,    32'h0,         5'd1, 5'd2,  5'd14, 4'b0110, 6'b001000);
        f   = inst(32'h38,  32'h3,    32'h4,    32'h0,         5'd3, 5'd4,  5'd15, 4'b0001, 6'b001000);
        l2  = inst(32'h40,  32'h300,  32'h0,    32'h8,         5'd1, 5'd0,  5'd7,  4'b0010, 6'b101101);
        u2  = inst(32'h44,  32'h1,    32'hDEAD, 32'h0,         5'd1, 5'd7,  5'd16, 4'b0010, 6'b001000);
        sw  = inst(32'h48,  32'h50,   32'h60,   32'hC,         5'd2, 5'd3,  5'd0,  4'b0010, 6'b100010);
        l3  = inst(32'h50,  32'h0,    32'h0,    32'h10,        5'd0, 5'd0,  5'd5,  4'b0010, 6'b101101);
        u3  = inst(32'h54,  32'h0,    32'h0,    32'h0,         5'd5, 5'd0,  5'd6,  4'b0010, 6'b001000);
        s_ex  = ex(32'h1234, 32'h0, 4'b0010, 32'h0, 5'd13, 5'b11000, 1'b0);
        l2_ex = ex(32'h300,  32'h8, 4'b0010, 32'h0, 5'd7,  5'b11101, 1'b1);
        a_raw = ex(32'h11,   32'h22, 4'b0010, 32'h22, 5'd8, 5'b11000, 1'b0);

        // Each expectation is the EX view produced by the previous row's edge, under this row's inputs.
        add(ctrl_in(a, 1'b1, 1'b0, 1'b0), z, 1'b0);
        add(ctrl_in(a, 1'b1, 1'b0, 1'b0), z, 1'b1);
        add(a, z, 1'b1);
        add(fw(b, 1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'h55), ex(32'hAA, 32'h22, 4'b0010, 32'h22, 5'd8, 5'b11000, 1'b0), 1'b1);
        add(fw(c, 1'b1, 5'd0, 32'hAA, 1'b1, 5'd6, 32'h55), ex(32'h33, 32'h55, 4'b0110, 32'h55, 5'd9, 5'b11000, 1'b0), 1'b1);
        add(fw(d, 1'b1, 5'd2, 32'hBEEF, 1'b0, 5'd0, 32'h0), ex(32'h7, 32'hFFFF_FFF0, 4'b0010, 32'hBEEF, 5'd3, 5'b11000, 1'b0), 1'b1);
        add(l, ex(32'h100, 32'h1000, 4'b0010, 32'h0, 5'd10, 5'b11000, 1'b0), 1'b1);
        add(u, ex(32'h200, 32'h4, 4'b0010, 32'h0, 5'd7, 5'b11101, 1'b1), 1'b1);
        add(fw(u, 1'b1, 5'd7, 32'h204, 1'b0, 5'd0, 32'h0), z, 1'b1);
        add(fw(s, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hCAFE), ex(32'hCAFE, 32'h5, 4'b0010, 32'h5, 5'd11, 5'b11000, 1'b0), 1'b1);
        add(fw(ctrl_in(t, 1'b0, 1'b1, 1'b0), 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234), s_ex, 1'b1);
        add(ctrl_in(t, 1'b0, 1'b1, 1'b0), s_ex, 1'b1);
        add(fw(ctrl_in(t, 1'b0, 1'b1, 1'b0), 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h9999), s_ex, 1'b1);
        add(t, s_ex, 1'b1);
        add(ctrl_in(f, 1'b0, 1'b1, 1'b1), ex(32'h1, 32'h2, 4'b0110, 32'h2, 5'd14, 5'b11000, 1'b0), 1'b1);
        add(nop, z, 1'b1);
        add(l2, z, 1'b1);
        add(ctrl_in(u2, 1'b0, 1'b1, 1'b0), l2_ex, 1'b1);
        add(u2, l2_ex, 1'b1);
        add(fw(u2, 1'b1, 5'd7, 32'h308, 1'b0, 5'd0, 32'h0), z, 1'b1);
        add(fw(sw, 1'b1, 5'd1, 32'h77, 1'b1, 5'd7, 32'hF00D), ex(32'h77, 32'hF00D, 4'b0010, 32'hF00D, 5'd16, 5'b11000, 1'b0), 1'b1);
        add(nop, ex(32'h50, 32'hC, 4'b0010, 32'h60, 5'd0, 5'b10010, 1'b0), 1'b1);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i].in, tbl[i].exp, tbl[i].chk, $sformatf("tbl%0d", i));

        // Flush coinciding with a load-use hazard, then a two-cycle reset mid-stream.
        apply(l3, z, 1'b1, "lu_flush_load");
        apply(ctrl_in(u3, 1'b0, 1'b0, 1'b1), ex(32'h0, 32'h10, 4'b0010, 32'h0, 5'd5, 5'b11101, 1'b1), 1'b1, "lu_flush_detect");
        apply(a, z, 1'b1, "lu_flush_bubble");
        apply(ctrl_in(a, 1'b1, 1'b0, 1'b0), a_raw, 1'b1, "rst_pre");
        apply(ctrl_in(a, 1'b1, 1'b0, 1'b0), z, 1'b1, "rst_cycle1");
        apply(a, z, 1'b1, "rst_after");
        apply(nop, a_raw, 1'b1, "rst_resume");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
